// File: rtl/spi_pkg.sv
// Shared SPI definitions: responder FSM encoding and bus mode constants.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin with registered rise/fall strobes.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RST_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              dly_r;
    // Fills with ones after reset; strobes stay masked until the preset levels have
    // flushed out, so a pin already at its active level is not reported as an edge.
    logic [STAGES:0]   prime_r;

    assign dout = sync_r[STAGES-1];

    // Synchronizer chain, edge-detect delay flop and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r  <= {STAGES{RST_LEVEL}};
            dly_r   <= RST_LEVEL;
            prime_r <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_r  <= {sync_r[STAGES-2:0], din};
            dly_r   <= sync_r[STAGES-1];
            prime_r <= {prime_r[STAGES-1:0], 1'b1};
            rise    <= prime_r[STAGES] &  sync_r[STAGES-1] & ~dly_r;
            fall    <= prime_r[STAGES] & ~sync_r[STAGES-1] &  dly_r;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled pins, one WIDTH-bit word in and out per frame.
module spi_slave
    import spi_pkg::*;
#(
    parameter int WIDTH       = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_dat,
    output logic [WIDTH-1:0] rx_dat,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             sclk_rise_s;
    logic             sclk_fall_s;
    logic             cs_rise_s;
    logic             cs_fall_s;
    logic             mosi_s;
    state_t           state_r;
    logic [WIDTH-1:0] tx_shift_r;
    logic [WIDTH-1:0] rx_shift_r;
    logic [WIDTH-1:0] rx_next_s;
    logic [CW-1:0]    cnt_r;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_LEVEL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk), .dout(), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_LEVEL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(cs_n), .dout(), .rise(cs_rise_s), .fall(cs_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_LEVEL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(mosi), .dout(mosi_s), .rise(), .fall()
    );

    assign rx_next_s = {rx_shift_r[WIDTH-2:0], mosi_s};

    // Frame FSM with all pin-side and word-side outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            tx_shift_r <= '0;
            rx_shift_r <= '0;
            cnt_r      <= '0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            rx_dat     <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cs_fall_s) begin
                        tx_shift_r <= tx_dat;
                        cnt_r      <= '0;
                        miso       <= tx_dat[WIDTH-1];
                        miso_oe    <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= ACTIVE;
                    end else begin
                        miso    <= 1'b0;
                        miso_oe <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                ACTIVE: begin
                    // A final rise coinciding with deselect still completes the word.
                    if (sclk_rise_s && (cnt_r == CW'(WIDTH - 1))) begin
                        rx_shift_r <= rx_next_s;
                        cnt_r      <= cnt_r + CW'(1);
                        rx_dat     <= rx_next_s;
                        rx_valid   <= 1'b1;
                        miso       <= 1'b0;
                        if (cs_rise_s) begin
                            miso_oe <= 1'b0;
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            state_r <= DONE;
                        end
                    end else if (cs_rise_s) begin
                        frame_err <= 1'b1;
                        miso      <= 1'b0;
                        miso_oe   <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end else if (sclk_rise_s) begin
                        rx_shift_r <= rx_next_s;
                        cnt_r      <= cnt_r + CW'(1);
                    end else if (sclk_fall_s && (cnt_r < CW'(WIDTH))) begin
                        tx_shift_r <= tx_shift_r << 1;
                        miso       <= tx_shift_r[WIDTH-2];
                    end else begin
                        state_r <= ACTIVE;
                    end
                end
                DONE: begin
                    miso <= 1'b0;
                    if (cs_rise_s) begin
                        miso_oe <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    miso    <= 1'b0;
                    miso_oe <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-0 master plus a scoreboard of expected rx events.
module tb_spi_slave;

    localparam int WIDTH = 13;

    typedef struct {
        bit               is_err;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sclk = 1'b0;
    logic             cs_n = 1'b1;
    logic             mosi = 1'b0;
    logic             miso;
    logic             miso_oe;
    logic [WIDTH-1:0] tx_dat = '0;
    logic [WIDTH-1:0] rx_dat;
    logic             rx_valid;
    logic             frame_err;
    logic             busy;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] got;

    spi_slave #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_dat(tx_dat), .rx_dat(rx_dat),
        .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = w;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = '0;
        exp_q.push_back(e);
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_stop();
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // SCLK = clk/8; MISO sampled at the moment SCLK is driven high.
    task automatic xfer(input logic [31:0] word, input int nbits, output logic [31:0] rdat);
        rdat = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = word[i];
            repeat (4) @(negedge clk);
            rdat = {rdat[30:0], miso};
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    // Scoreboard monitor: every rx_valid / frame_err pulse must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                if (exp_q.size() == 0) begin
                    check("rx_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rx_valid_kind", {31'd0, mon_e.is_err}, 32'd0);
                    check("rx_dat", {19'd0, rx_dat}, {19'd0, mon_e.data});
                end
            end
            if (frame_err) begin
                if (exp_q.size() == 0) begin
                    check("frame_err_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("frame_err_kind", {31'd0, mon_e.is_err}, 32'd1);
                end
            end
        end
    end

    initial begin
        repeat (4) @(negedge clk);
        check("reset_ctrl", {27'd0, miso, miso_oe, rx_valid, frame_err, busy}, 32'd0);
        check("reset_rx_dat", {19'd0, rx_dat}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Normal frame
        tx_dat = 13'h0ced;
        push_word(13'h1dad);
        cs_start();
        check("busy_in_frame", {30'd0, busy, miso_oe}, 32'd3);
        xfer(32'h1dad, WIDTH, got);
        check("miso_word_1", got, 32'h0ced);
        cs_stop();
        check("idle_after_frame", {30'd0, busy, miso_oe}, 32'd0);

        // Back-to-back frame; tx_dat change after frame start must be ignored
        tx_dat = 13'h0cee;
        push_word(13'h1dae);
        cs_start();
        tx_dat = 13'h1555;
        xfer(32'h1dae, WIDTH, got);
        check("miso_word_2", got, 32'h0cee);
        cs_stop();

        // Short frame
        push_err();
        cs_start();
        xfer(32'h15, 5, got);
        cs_stop();
        check("short_keeps_rx_dat", {19'd0, rx_dat}, 32'h1dae);
        check("short_idle", {30'd0, busy, miso_oe}, 32'd0);

        // Overclocked frame: 3 extra bits must read back as zero
        tx_dat = 13'h0ced;
        push_word(13'h1dad);
        cs_start();
        xfer({13'h1dad, 3'b111}, 16, got);
        check("overclock_miso", got, {16'd0, 13'h0ced, 3'b000});
        check("overclock_busy", {31'd0, busy}, 32'd1);
        cs_stop();
        check("overclock_rx_dat", {19'd0, rx_dat}, 32'h1dad);

        // Reset mid-frame, with CS_N still low when reset is released
        cs_start();
        xfer(32'h55, 7, got);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_ctrl", {27'd0, miso, miso_oe, rx_valid, frame_err, busy}, 32'd0);
        check("midreset_rx_dat", {19'd0, rx_dat}, 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("no_start_cs_low", {30'd0, busy, miso_oe}, 32'd0);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        tx_dat = 13'h0a5a;
        push_word(13'h0001);
        cs_start();
        xfer(32'h0001, WIDTH, got);
        check("post_reset_miso", got, 32'h0a5a);
        cs_stop();

        // Final SCLK rise coincides with CS_N rise
        tx_dat = 13'h0ced;
        push_word(13'h1dad);
        cs_start();
        xfer(32'h1dad >> 1, WIDTH - 1, got);
        mosi = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        check("coincide_idle", {30'd0, busy, miso_oe}, 32'd0);
        check("coincide_rx_dat", {19'd0, rx_dat}, 32'h1dad);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) for the existing SPI master path; complements it as the far end of the link.
- Oversamples the SCLK, CS_N and MOSI pins in the system clock domain.
- Shifts in one WIDTH-bit word from MOSI per frame and shifts out a parallel-loaded word on MISO.
- Sits between the board pins and the display/LED logic: parallel rx/tx words on one side, raw SPI pins on the other.

Parameters:
- WIDTH, 13, frame length in bits; legal range 2..32.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers; legal range 2..3.

Ports:
- clk  input  1  system clock, 27 MHz on board.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  SPI serial clock from the master; asynchronous to clk.
- cs_n  input  1  SPI chip select, active low; asynchronous.
- mosi  input  1  master-out serial data; asynchronous.
- miso  output  1  slave-out serial data.
- miso_oe  output  1  high while selected; the top level builds the tristate from it.
- tx_dat  input  WIDTH  word to transmit; captured at frame start.
- rx_dat  output  WIDTH  last complete received word; held between frames.
- rx_valid  output  1  one-cycle pulse when rx_dat updates.
- frame_err  output  1  one-cycle pulse when a frame is aborted short.
- busy  output  1  high from frame start until frame end.

Behaviour:
- Reset values (rst=1 at a clk edge):
  - miso=0, miso_oe=0, rx_dat=0, rx_valid=0, frame_err=0, busy=0.
  - Shift registers cleared, bit counter=0, FSM in IDLE.
  - Synchronizer flops preset to idle levels: sclk=0, cs_n=1, mosi=0.
- Input synchronization and edge detection:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - Edge detection compares the last synchronized stage with one extra delayed flop.
  - Result: sclk_rise, sclk_fall, cs_fall and cs_rise single-cycle strobes.
- Timing requirement on the master:
  - SCLK high and low phases each >= 4 clk periods.
  - First SCLK rise >= SYNC_STAGES+3 clk after CS_N falls.
- FSM states: IDLE, ACTIVE, DONE.
- IDLE:
  - miso_oe=0, busy=0.
  - On cs_fall: tx_shift <= tx_dat, cnt <= 0, miso <= tx_dat[WIDTH-1], miso_oe <= 1, busy <= 1; go to ACTIVE.
  - The MSB is valid on the pin SYNC_STAGES+2 clk after the raw CS_N fall.
- ACTIVE:
  - On sclk_rise: rx_shift <= {rx_shift[WIDTH-2:0], mosi_s}; cnt <= cnt+1.
  - When cnt reaches WIDTH-1 on that edge: rx_dat <= the completed word, rx_valid=1 the next cycle; go to DONE.
  - On sclk_fall with cnt < WIDTH: tx_shift shifts left; miso <= next bit.
  - On cs_rise before WIDTH bits are complete: frame_err=1 for one cycle, rx_dat unchanged, miso_oe <= 0, busy <= 0; go to IDLE.
- DONE:
  - All further sclk edges are ignored; rx_dat is not rewritten; miso=0 (overclocked bits read as 0).
  - On cs_rise: miso_oe <= 0, busy <= 0; go to IDLE.
- Simultaneous events:
  - cs_rise in the same cycle as the final sclk_rise: the word completes (rx_valid=1) and the FSM goes straight to IDLE; no frame_err.
  - cs_fall is seen only in IDLE. CS_N low at reset release does not start a frame; CS_N must go high, then low.
- tx_dat is sampled only at frame start; changes mid-frame have no effect.
- rst mid-frame: outputs return to reset values immediately; no rx_valid and no frame_err are generated for the aborted frame.
- Counter width: $clog2(WIDTH+1); the counter never wraps.

Decomposition:
- Shared package spi_pkg:
  - FSM state encoding (IDLE/ACTIVE/DONE).
  - Mode constants CPOL=0, CPHA=0, reused later by a configurable-mode master.
- One sub-module, spi_sync_edge:
  - SYNC_STAGES synchronizer plus rise/fall strobe generation.
  - Parameterized reset level.
  - Instantiated for sclk and cs_n; the same module with strobes unused serves mosi.

Test Plan:
- Normal frame: tx_dat=13'h0ced; master sends 13'h1dad with SCLK = clk/8 -> rx_dat=13'h1dad, one rx_valid pulse, master receives 13'h0ced, busy low after CS_N rises.
- Back-to-back frames: 13'h1dad then 13'h1dae; tx_dat incremented between them -> two rx_valid pulses with correct words, second MISO word = 13'h0cee.
- Short frame: CS_N rises after 5 SCLK rises -> frame_err pulse, rx_dat keeps its previous value, no rx_valid.
- Overclock: 16 SCLK pulses carrying 13'h1dad plus 3 extra bits -> rx_dat=13'h1dad, exactly one rx_valid, MISO=0 for bits 14-16.
- Reset mid-frame: rst asserted after 7 bits -> all outputs at reset values the next cycle. A full frame 13'h0001 afterwards is received correctly.
- Coincidence: final SCLK rise and CS_N rise aligned in the same synchronized cycle -> rx_valid=1, frame_err=0, FSM returns to IDLE.
